// File: rtl/alu_pkg.sv
// Shared ALU types and constants: FSM state encoding and nibble geometry
// for the serial add/subtract sequencer.
package alu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int NIBBLE_W = 4;

  function automatic int num_nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width / NIBBLE_W);
  endfunction

endpackage

// File: rtl/RippleCarryAdder_4bit.sv
// Shared 4-bit ripple-carry adder slice: sum = a + b + cin, carry out of bit 3.
module RippleCarryAdder_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[4];

endmodule

// File: rtl/serial_add_sequencer.sv
// Multi-cycle add/subtract: feeds WIDTH-bit operands one nibble per cycle,
// LSB first, through a single 4-bit adder slice with a registered carry.
module serial_add_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N     = num_nibbles(WIDTH);
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(N - 1);

  state_t                    state_q;
  logic [CNT_W-1:0]          k_q;
  logic [WIDTH-1:0]          a_q, b_q;
  logic [WIDTH-NIBBLE_W-1:0] acc_q;
  logic                      carry_q;
  logic                      a_msb_q, b_msb_q;
  logic                      ready_q, busy_q, done_q;
  logic [WIDTH-1:0]          sum_q;
  logic                      c_out_q, ovf_q;

  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;
  logic [WIDTH-1:0]    acc_d;
  logic [WIDTH-1:0]    b_eff;

  RippleCarryAdder_4bit u_slice (
    .a_i    (a_q[NIBBLE_W-1:0]),
    .b_i    (b_q[NIBBLE_W-1:0]),
    .cin_i  (carry_q),
    .sum_o  (nib_sum),
    .cout_o (nib_cout)
  );

  // Newest nibble enters at the top, so after N shifts the LSB nibble is at the bottom.
  assign acc_d = {nib_sum, acc_q};
  assign b_eff = b ^ {WIDTH{sub}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            k_q     <= '0;
            a_q     <= a;
            b_q     <= b_eff;
            carry_q <= sub;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b_eff[WIDTH-1];
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          a_q     <= {{NIBBLE_W{1'b0}}, a_q[WIDTH-1:NIBBLE_W]};
          b_q     <= {{NIBBLE_W{1'b0}}, b_q[WIDTH-1:NIBBLE_W]};
          acc_q   <= acc_d[WIDTH-1:NIBBLE_W];
          carry_q <= nib_cout;
          k_q     <= k_q + 1'b1;
          if (k_q == K_LAST) begin
            state_q <= DONE;
            k_q     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= acc_d;
            c_out_q <= nib_cout;
            ovf_q   <= (a_msb_q == b_msb_q) && (nib_sum[NIBBLE_W-1] != a_msb_q);
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer: directed vectors, handshake
// corner cases and randomized operations against an arithmetic reference model.
module tb_serial_add_sequencer;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;
  localparam int LAT   = N + 1;

  logic             clk = 1'b0;
  logic             rst, start, sub;
  logic [WIDTH-1:0] a, b;
  logic             ready, busy, done, c_out, ovf;
  logic [WIDTH-1:0] sum;

  int errors = 0;
  int checks = 0;

  serial_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer add/subtract with signed-overflow from operand signs.
  function automatic void model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                input logic msub, output logic [WIDTH-1:0] ms,
                                output logic mc, output logic mv);
    longint unsigned ua, ub, r;
    longint sa, sb, sr;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (msub) begin
      r  = (ua - ub) & ((64'd1 << WIDTH) - 1);
      mc = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub;
      mc = r[WIDTH];
      sr = sa + sb;
    end
    ms = r[WIDTH-1:0];
    mv = (sr > ((64'sd1 <<< (WIDTH - 1)) - 1)) || (sr < -(64'sd1 <<< (WIDTH - 1)));
  endfunction

  // Drives start for one cycle; returns at the negedge of cycle 1.
  task automatic launch(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic tsub);
    a = ta; b = tb_; sub = tsub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; cyc is the cycle index at which it was seen.
  task automatic wait_done(inout int cyc);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({ready, busy, done, c_out, ovf} !== 5'b10000 || sum !== '0) begin
      errors++;
      $display("FAIL reset: ready=%b busy=%b done=%b c=%b v=%b sum=%h want 1 0 0 0 0 0000",
               ready, busy, done, c_out, ovf, sum);
    end
  endtask

  task automatic test_directed;
    logic [WIDTH-1:0] va[4] = '{16'h1234, 16'hFFFF, 16'h0005, 16'h7FFF};
    logic [WIDTH-1:0] vb[4] = '{16'h0FFF, 16'h0001, 16'h0007, 16'h0001};
    logic             vs[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [WIDTH-1:0] es[4] = '{16'h2233, 16'h0000, 16'hFFFE, 16'h8000};
    logic             ec[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic             ev[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      int cyc;
      @(negedge clk);
      launch(va[i], vb[i], vs[i]);
      cyc = 1;
      checks++;
      if (busy !== 1'b1 || ready !== 1'b0) begin
        errors++;
        $display("FAIL directed%0d_busy: busy=%b ready=%b want 1 0", i, busy, ready);
      end
      wait_done(cyc);
      checks++;
      if (cyc != LAT) begin
        errors++;
        $display("FAIL directed%0d_latency: done at cycle %0d want %0d", i, cyc, LAT);
      end
      checks++;
      if (sum !== es[i] || c_out !== ec[i] || ovf !== ev[i]) begin
        errors++;
        $display("FAIL directed%0d_result: sum=%h c=%b v=%b want %h %b %b",
                 i, sum, c_out, ovf, es[i], ec[i], ev[i]);
      end
    end
  endtask

  task automatic test_ignored_start;
    int cyc;
    @(negedge clk);
    launch(16'h1000, 16'h0234, 1'b0);
    cyc = 1;
    @(negedge clk); cyc++;
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 1'b1;
    @(negedge clk); cyc++;
    start = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc != LAT || sum !== 16'h1234 || c_out !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start: cyc=%0d sum=%h c=%b v=%b want %0d 1234 0 0",
               cyc, sum, c_out, ovf, LAT);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || sum !== 16'h1234) begin
      errors++;
      $display("FAIL after_done: done=%b ready=%b busy=%b sum=%h want 0 1 0 1234",
               done, ready, busy, sum);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    @(negedge clk);
    launch(16'h0100, 16'h0023, 1'b0);
    cyc = 1;
    wait_done(cyc);
    // Second request presented during the done cycle.
    launch(16'h0050, 16'h0060, 1'b1);
    cyc = 1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || sum !== 16'h0123) begin
      errors++;
      $display("FAIL b2b_accept: done=%b busy=%b sum=%h want 0 1 0123", done, busy, sum);
    end
    wait_done(cyc);
    checks++;
    if (cyc != LAT || sum !== 16'hFFF0 || c_out !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: cyc=%0d sum=%h c=%b v=%b want %0d fff0 0 0",
               cyc, sum, c_out, ovf, LAT);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    int seen;
    @(negedge clk);
    launch(16'h4321, 16'h1111, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1 || sum !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b ready=%b sum=%h want 0 0 1 0000",
               busy, done, ready, sum);
    end
    seen = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_nodone: saw %0d done pulses want 0", seen);
    end
    launch(16'h0001, 16'h0002, 1'b0);
    cyc = 1;
    wait_done(cyc);
    checks++;
    if (cyc != LAT || sum !== 16'h0003 || c_out !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: cyc=%0d sum=%h want %0d 0003", cyc, sum, LAT);
    end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] ra, rb, es;
    logic             rs, ec, ev;
    int               cyc, dpulse;
    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rs = 1'($urandom);
      if (i % 8 == 0) rb = ra;                 // zero / equal-operand corner
      if (i % 8 == 1) ra = {1'b1, {(WIDTH-1){1'b0}}};
      model(ra, rb, rs, es, ec, ev);
      if ($urandom_range(1, 0) == 1) @(negedge clk);
      launch(ra, rb, rs);
      cyc = 1;
      dpulse = 0;
      wait_done(cyc);
      checks++;
      if (cyc != LAT || sum !== es || c_out !== ec || ovf !== ev) begin
        errors++;
        $display("FAIL random%0d: a=%h b=%h sub=%b cyc=%0d sum=%h c=%b v=%b want %0d %h %b %b",
                 i, ra, rb, rs, cyc, sum, c_out, ovf, LAT, es, ec, ev);
      end
      if (i % 5 == 4) begin
        @(negedge clk);
        if (done) dpulse++;
        checks++;
        if (dpulse != 0 || sum !== es) begin
          errors++;
          $display("FAIL random%0d_hold: done repeated=%0d sum=%h want 0 %h", i, dpulse, sum, es);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_sequencer.md
# serial_add_sequencer

Multi-cycle add/subtract controller that sequences the team's 4-bit ripple-carry adder slice to process WIDTH-bit operands one nibble per cycle, LSB nibble first. It latches operands on a start/ready handshake and carries between nibbles in a register. It returns sum, carry and signed overflow with a one-cycle done pulse. It sits between the ALU front-end and the narrow adder datapath, trading latency for area.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- sub  input  1  0 = a+b, 1 = a-b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- ready  output  1  high in IDLE and DONE; start is accepted
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse; sum, c_out and ovf are valid
- sum  output  WIDTH  result; held until the next accepted start
- c_out  output  1  carry out of the MSB nibble; for sub, 1 = no borrow
- ovf  output  1  two's-complement signed overflow

## Operation
- States:
  - IDLE: ready=1.
  - RUN: busy=1, nibble index k counts 0..N-1, where N=WIDTH/4.
  - DONE: done=1, ready=1.
- Transitions:
  - IDLE→RUN on start.
  - RUN→RUN while k<N-1.
  - RUN→DONE when k=N-1.
  - DONE→RUN on start, otherwise DONE→IDLE.
- Accept: on start, latch a into shift register A and b into shift register B, inverting B when sub=1.
- Carry register init on accept: cin = sub.
- Each RUN cycle: the adder slice takes A[3:0], B[3:0] and the carry register.
  - Its 4-bit sum shifts into the top of the sum register.
  - A and B shift right by 4.
  - The carry register takes the slice's carry out.
- Final RUN cycle:
  - c_out = the slice's carry out.
  - ovf = (a_msb == beff_msb) && (sum_msb != a_msb), where beff = b ^ {WIDTH{sub}}, using the latched a and beff MSBs.
- Start is ignored while busy=1. Operand or sub changes after acceptance have no effect.
- Results are arithmetic mod 2^WIDTH. No saturation.

## Timing
- Reset, effective at the next clk edge, sets:
  - state = IDLE
  - ready = 1
  - busy = 0
  - done = 0
  - sum = 0
  - c_out = 0
  - ovf = 0
  - k = 0
  - carry register = 0
- Reset during RUN aborts the operation. No done is produced for it.
- Start sampled at edge 0 → busy=1 for cycles 1..N → done=1 in cycle N+1 (WIDTH=16: done in cycle 5).
- Latency from start to done is N+1 cycles.
- Throughput is one operation per N+1 cycles when start is held.
- done is never high for more than one consecutive cycle.
- sum, c_out and ovf change only on the final RUN edge, or on reset.
- Start in DONE: done is still high that cycle; busy=1 on the next cycle.
- rst and start high on the same edge: rst wins; state is IDLE.

## Structure
- Shared package (alu_pkg):
  - state typedef {IDLE, RUN, DONE}
  - NIBBLE_W = 4
  - derived constant N = WIDTH/NIBBLE_W and the counter width $clog2(N)
- One sub-module instance: the existing 4-bit ripple-carry adder slice (RippleCarryAdder_4bit). Do not re-implement it in this block.
- Control FSM, counter, shift registers and flag logic are local to serial_add_sequencer.

## Test plan
- Basic add: WIDTH=16, a=0x1234, b=0x0FFF, sub=0, start at cycle 0 → done only in cycle 5; sum=0x2233, c_out=0, ovf=0.
- Full carry ripple: a=0xFFFF, b=0x0001, add → sum=0x0000, c_out=1, ovf=0.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, c_out=0, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, add → sum=0x8000, ovf=1, c_out=0.
- Ignored start and back-to-back:
  - Pulse start with new operands during RUN → ignored; the first result is unchanged.
  - Start in the DONE cycle → second op accepted; its done arrives 5 cycles later.
- Reset mid-operation: rst at cycle 2 of RUN → next cycle busy=0, done=0, sum=0, ready=1. A following add 0x0001+0x0002 returns 0x0003.
